// File: rtl/reflet_float_div_pkg.sv
// Shared float-format helpers and FSM encoding for the iterative divider.
// REFLET_FLOAT_DIV_ROUND_EN adds a guard step to the division and lengthens the latency.
package reflet_float_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        NORMALIZE,
        DONE
    } div_state_e;

    function automatic int exponent_size(input int float_size);
        case (float_size)
            16:      return 5;
            64:      return 11;
            128:     return 15;
            default: return 8;
        endcase
    endfunction

    function automatic int mantissa_size(input int float_size);
        return float_size - exponent_size(float_size) - 1;
    endfunction

    function automatic int exponent_bias(input int float_size);
        return (1 << (exponent_size(float_size) - 1)) - 1;
    endfunction

    // Number of quotient bits produced by the mantissa loop.
    function automatic int quotient_bits(input int float_size);
`ifdef REFLET_FLOAT_DIV_ROUND_EN
        return mantissa_size(float_size) + 3;
`else
        return mantissa_size(float_size) + 2;
`endif
    endfunction

    // Edges from the enable-sampling edge to ready, for the dispatcher.
    function automatic int division_time(input int float_size);
        return quotient_bits(float_size) + 1;
    endfunction

endpackage

// File: rtl/reflet_float_div_mant.sv
// Restoring mantissa divider: one quotient bit per clock after a start pulse.
// done is high during the cycle the final bit is produced; results hold until the next start.
module reflet_float_div_mant
    import reflet_float_div_pkg::*;
#(
    parameter int size  = 24,
    parameter int steps = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [size-1:0]  dividend,
    input  logic [size-1:0]  divisor,
    output logic [steps-1:0] quotient,
    output logic             remainder_nonzero,
    output logic             done
);

    localparam int CW = $clog2(steps);

    logic [size:0]    rem_q, rem_d;
    logic [size-1:0]  dvs_q, dvs_d;
    logic [steps-1:0] quot_q, quot_d;
    logic [CW-1:0]    count_q, count_d;
    logic             busy_q, busy_d;
    logic             ge;

    assign ge                = rem_q >= {1'b0, dvs_q};
    assign done              = busy_q && (count_q == CW'(steps - 1));
    assign quotient          = quot_q;
    assign remainder_nonzero = |rem_q;

    always_comb begin
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        count_d = count_q;
        busy_d  = busy_q;
        if (start) begin
            rem_d   = {1'b0, dividend};
            dvs_d   = divisor;
            quot_d  = '0;
            count_d = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            // The partial remainder stays below the divisor, so the shift never loses a bit.
            rem_d   = (ge ? rem_q - {1'b0, dvs_q} : rem_q) << 1;
            quot_d  = {quot_q[steps-2:0], ge};
            count_d = count_q + CW'(1);
            if (done) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q   <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            count_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            count_q <= count_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: rtl/reflet_float_div.sv
// Iterative floating-point divider (in1 / in2) using the FPU enable/ready handshake.
// Define REFLET_FLOAT_DIV_ROUND_EN for round-to-nearest-even instead of truncation.
module reflet_float_div
    import reflet_float_div_pkg::*;
#(
    parameter int float_size = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [float_size-1:0] in1,
    input  logic [float_size-1:0] in2,
    output logic [float_size-1:0] div,
    output logic                  ready
);

    localparam int E  = exponent_size(float_size);
    localparam int M  = mantissa_size(float_size);
    localparam int QW = quotient_bits(float_size);
    localparam logic [E-1:0] BIAS_E = E'(exponent_bias(float_size));
    localparam logic [E-1:0] ONE_E  = E'(1);

    div_state_e                  state_q, state_d;
    logic [2*float_size-1:0]     captured_q, captured_d;
    logic [float_size-1:0]       div_q, div_d;
    logic                        ready_q, ready_d;
    logic                        start;
    logic [QW-1:0]               quotient;
    logic                        rem_nz;
    logic                        mant_done;
    logic                        operands_changed;

    logic [float_size-1:0]       op_a, op_b, result;
    logic                        sign, q_msb;
    logic [E-1:0]                exp_base, exp_norm, exp_final;
    logic [M-1:0]                mant_trunc, mant_final;
`ifdef REFLET_FLOAT_DIV_ROUND_EN
    logic                        guard, sticky, round_up, carry;
`else
    logic                        sticky_unused;
    // The leftover remainder only matters when rounding.
    assign sticky_unused = rem_nz;
`endif

    reflet_float_div_mant #(
        .size  (M + 1),
        .steps (QW)
    ) u_mant (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .dividend          ({1'b1, in1[M-1:0]}),
        .divisor           ({1'b1, in2[M-1:0]}),
        .quotient          (quotient),
        .remainder_nonzero (rem_nz),
        .done              (mant_done)
    );

    assign op_a             = captured_q[2*float_size-1 -: float_size];
    assign op_b             = captured_q[float_size-1:0];
    assign operands_changed = {in1, in2} != captured_q;
    assign div              = div_q;
    assign ready            = ready_q;

    always_comb begin
        sign       = op_a[float_size-1] ^ op_b[float_size-1];
        exp_base   = op_a[float_size-2 -: E] - op_b[float_size-2 -: E] + BIAS_E;
        q_msb      = quotient[QW-1];
        exp_norm   = q_msb ? exp_base : exp_base - ONE_E;
        mant_trunc = q_msb ? quotient[QW-2 -: M] : quotient[QW-3 -: M];
`ifdef REFLET_FLOAT_DIV_ROUND_EN
        guard      = q_msb ? quotient[1] : quotient[0];
        sticky     = (q_msb & quotient[0]) | rem_nz;
        round_up   = guard & (sticky | mant_trunc[0]);
        {carry, mant_final} = {1'b0, mant_trunc} + {{M{1'b0}}, round_up};
        exp_final  = exp_norm + {{(E-1){1'b0}}, carry};
`else
        mant_final = mant_trunc;
        exp_final  = exp_norm;
`endif
        if (op_a[float_size-2:0] == '0) begin
            result = {sign, {(float_size-1){1'b0}}};
        end else if (op_b[float_size-2:0] == '0) begin
            result = {sign, {E{1'b1}}, {M{1'b0}}};
        end else begin
            result = {sign, exp_final, mant_final};
        end
    end

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        start      = 1'b0;
        ready_d    = 1'b0;
        div_d      = '0;
        if (!enable) begin
            state_d = IDLE;
        end else if (state_q == IDLE || operands_changed) begin
            state_d    = DIVIDE;
            captured_d = {in1, in2};
            start      = 1'b1;
        end else begin
            case (state_q)
                DIVIDE: begin
                    if (mant_done) begin
                        state_d = NORMALIZE;
                    end
                end
                NORMALIZE: begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    div_d   = result;
                end
                DONE: begin
                    ready_d = 1'b1;
                    div_d   = div_q;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            captured_q <= '0;
            div_q      <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            div_q      <= div_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: doc/reflet_float_div.md
Name: reflet_float_div

Overview:
- Iterative floating-point divider; the inverse operation of the FPU's multiplier.
- Computes in1 / in2 for the same float_size format.
- Uses restoring division on the mantissas, one quotient bit per clock.
- Uses the FPU's enable/ready handshake, so the FPU dispatcher can drive it exactly like the other operators.

Parameters:
- float_size, 32, total float width. Exponent width, mantissa width and bias come from the shared float functions. For the default: E=8, M=23, bias=127.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- enable  input  1  request/hold operation; low aborts
- in1  input  float_size  dividend
- in2  input  float_size  divisor
- div  output  float_size  quotient; 0 whenever ready is low
- ready  output  1  registered; high while div is valid for the current in1/in2

Interface: one clock, clk; reset is synchronous and active-high, port named reset.

Behaviour:
- Reset:
  - State IDLE; ready=0; div=0; internal registers cleared.
  - reset has priority over all other events, including mid-division.
- Captured copy: on entering DIVIDE the block stores {in1,in2} in a captured register.
- FSM states: IDLE, DIVIDE, NORMALIZE, DONE.
  - IDLE: if enable is high, capture operands, load remainder={1,mnt1}, divisor={1,mnt2}, clear quotient and counter, go to DIVIDE.
  - DIVIDE: each cycle:
    - if remainder >= divisor, remainder -= divisor and shift in quotient bit 1; else shift in 0.
    - remainder <<= 1.
    - After M+2 cycles go to NORMALIZE. Q is M+2 bits, value in (0.5, 2).
  - NORMALIZE:
    - If Q[M+1]=1: mantissa=Q[M:1], exp=e1-e2+bias.
    - Else: mantissa=Q[M-1:0], exp=e1-e2+bias-1.
    - Exponent arithmetic is modulo 2^E; no overflow/underflow/denormal detection.
    - Truncation, no rounding. Register the result, go to DONE.
  - DONE: ready=1; div=result register. Hold until enable falls or the operands change.
- Sign: sign1 ^ sign2 in every case.
- Special cases, applied in NORMALIZE:
  - in1[float_size-2:0]==0 → magnitude 0.
  - else in2[float_size-2:0]==0 → exponent all ones, mantissa 0 (infinity).
  - 0/0 gives zero.
  - Latency is the same as for normal operands.
- Latency: ready rises M+3 clock edges after the edge that samples enable in IDLE (26 for float32).
- Enable falling in any state: next state IDLE, ready=0, div=0. Any partial result is discarded.
- Operand change: if enable is high and {in1,in2} differs from the captured copy in DIVIDE, NORMALIZE or DONE:
  - ready goes to 0 on the next edge.
  - The block recaptures and restarts DIVIDE; full latency applies again.
- Enable high continuously with unchanged operands: a single computation; ready stays high.

Optional Feature:
- Macro: REFLET_FLOAT_DIV_ROUND_EN.
- Defined:
  - DIVIDE runs M+3 cycles; the extra quotient bit is the guard bit.
  - The remainder after the last step is the sticky bit.
  - Round to nearest, ties to even.
  - A carry out of the mantissa increments the exponent and clears the mantissa.
  - Latency is M+4 (27 for float32).
- Undefined: truncation, latency M+3.

Decomposition:
- Shared include reflet_float_functions.vh already provides mantissa_size, exponent_size and exponent_bias; reuse them.
- Add `division_time` to reflet_float_opperations.vh (M+3, or M+4 under the macro) so the dispatcher knows the latency.
- One sub-module: reflet_float_div_mant.
  - Parameterized (size) iterative mantissa divider.
  - Ports: clk, reset, start, dividend, divisor → quotient, remainder_nonzero, done.
  - Owns the DIVIDE loop and counter; the top handles the FSM, exponent, sign, specials and handshake.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2), enable held → ready after 26 edges, div=0x40400000.
- 0x3F800000 / 0x40400000 (1/3) → 0x3EAAAAAA; with REFLET_FLOAT_DIV_ROUND_EN, 0x3EAAAAAB after 27 edges.
- 0xC1000000 / 0x3F000000 (-8/0.5) → 0xC1800000; 0x00000000 / 0x40A00000 → 0x00000000.
- 0x3F800000 / 0x00000000 → 0x7F800000; 0xBF800000 / 0x80000000 → 0x7F800000 (sign xor 0).
- Change in2 from 0x40000000 to 0x40800000 at edge 10 of 6/2 → ready stays 0, then after 26 more edges div=0x3FC00000.
- Deassert enable mid-DIVIDE, or assert reset in DONE → next edge ready=0, div=0, state IDLE; re-enable restarts with full latency.
